// File: rtl/mac_result_drain.sv
// mac_result_drain
//   Read-side companion to the 2x2 MAC array. A start pulse in IDLE captures
//   all four accumulators in one edge, pulses clear_all for one cycle, then
//   streams the four results (order 00, 01, 10, 11) over a valid/ready port
//   after a logical right shift and unsigned saturation to OUT_WIDTH bits.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   start                   drain request, only honoured in IDLE
//   acc_00..acc_11          unsigned accumulators from the MAC array
//   clear_all               one-cycle clear pulse to the MAC array
//   busy                    high whenever a drain is in progress
//   out_valid / out_ready   result beat handshake
//   out_data                narrowed result
//   out_index               source MAC of the beat (0=00 1=01 2=10 3=11)
//   out_last                marks the index-3 beat
//   out_sat                 beat was clipped to all ones
//   done                    one-cycle pulse after the last beat is accepted
module mac_result_drain #(
    parameter int ACC_WIDTH = 20,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ACC_WIDTH-1:0] acc_00,
    input  logic [ACC_WIDTH-1:0] acc_01,
    input  logic [ACC_WIDTH-1:0] acc_10,
    input  logic [ACC_WIDTH-1:0] acc_11,
    output logic                 clear_all,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [1:0]           out_index,
    output logic                 out_last,
    output logic                 out_sat,
    output logic                 done
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state, state_next;
    logic [ACC_WIDTH-1:0] snap [4];
    logic                 load_snap;
    logic                 clear_next, valid_next, done_next, last_next;
    logic [1:0]           index_next;
    logic [OUT_WIDTH:0]   beat_next;   // {sat, data}

    // Shift then clip; returns {sat, data}. Any bit surviving above
    // OUT_WIDTH after the shift means the value does not fit.
    function automatic logic [OUT_WIDTH:0] narrow(input logic [ACC_WIDTH-1:0] v);
        logic [ACC_WIDTH-1:0] s;
        s = v >> SHIFT;
        if ((s >> OUT_WIDTH) != '0)
            return {1'b1, {OUT_WIDTH{1'b1}}};
        return {1'b0, s[OUT_WIDTH-1:0]};
    endfunction

    assign busy = (state != IDLE);

    always_comb begin
        state_next = state;
        load_snap  = 1'b0;
        clear_next = 1'b0;
        done_next  = 1'b0;
        valid_next = out_valid;
        index_next = out_index;
        last_next  = out_last;
        beat_next  = {out_sat, out_data};
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                    load_snap  = 1'b1;
                    clear_next = 1'b1;
                    valid_next = 1'b1;
                    index_next = 2'd0;
                    last_next  = 1'b0;
                    // First beat comes straight from the input so it is
                    // ready one cycle after the start edge.
                    beat_next  = narrow(acc_00);
                end
            end
            STREAM: begin
                if (out_valid && out_ready) begin
                    if (out_index == 2'd3) begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        index_next = out_index + 2'd1;
                        last_next  = (out_index == 2'd2);
                        beat_next  = narrow(snap[index_next]);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            clear_all <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_index <= 2'd0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < 4; i++) snap[i] <= '0;
        end else begin
            state     <= state_next;
            clear_all <= clear_next;
            out_valid <= valid_next;
            done      <= done_next;
            out_index <= index_next;
            out_last  <= last_next;
            {out_sat, out_data} <= beat_next;
            if (load_snap) begin
                snap[0] <= acc_00;
                snap[1] <= acc_01;
                snap[2] <= acc_10;
                snap[3] <= acc_11;
            end
        end
    end

endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain: two instances (SHIFT=0 and SHIFT=4) share the
// stimulus; expected beats come from a fixed table or from a reference
// narrowing function applied to the values presented at start.
module tb_mac_result_drain;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [19:0] acc [4];

    logic [1:0]  clr, bsy, vld, lst, sat, dn;
    logic [15:0] dat [2];
    logic [1:0]  idx [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mac_result_drain dut0 (
        .clock(clock), .reset(reset), .start(start),
        .acc_00(acc[0]), .acc_01(acc[1]), .acc_10(acc[2]), .acc_11(acc[3]),
        .clear_all(clr[0]), .busy(bsy[0]), .out_valid(vld[0]), .out_ready(out_ready),
        .out_data(dat[0]), .out_index(idx[0]), .out_last(lst[0]), .out_sat(sat[0]),
        .done(dn[0])
    );

    mac_result_drain #(.SHIFT(4)) dut1 (
        .clock(clock), .reset(reset), .start(start),
        .acc_00(acc[0]), .acc_01(acc[1]), .acc_10(acc[2]), .acc_11(acc[3]),
        .clear_all(clr[1]), .busy(bsy[1]), .out_valid(vld[1]), .out_ready(out_ready),
        .out_data(dat[1]), .out_index(idx[1]), .out_last(lst[1]), .out_sat(sat[1]),
        .done(dn[1])
    );

    typedef struct {
        logic [3:0][19:0] a;
        logic [3:0][15:0] e0;
        logic [3:0]       s0;
        logic [3:0][15:0] e1;
        logic [3:0]       s1;
        int               rmode;   // 0 always ready, 1 random, 2 stall beat 1 for 3 cycles
        bit               noise;   // spurious start pulses while streaming
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", nm, d, act, exp);
        end
    endtask

    // Reference narrowing: shift, then clip to 16 bits.
    function automatic void ref_narrow(input logic [19:0] v, input int sh,
                                       output logic [15:0] d, output logic s);
        longint x;
        x = longint'(v) / (longint'(1) << sh);
        if (x > 65535) begin d = 16'hFFFF; s = 1'b1; end
        else begin d = 16'(x); s = 1'b0; end
    endfunction

    task automatic check_idle(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk({nm, "_valid"}, d, 32'(vld[d]), 0);
            chk({nm, "_busy"},  d, 32'(bsy[d]), 0);
            chk({nm, "_clear"}, d, 32'(clr[d]), 0);
            chk({nm, "_done"},  d, 32'(dn[d]),  0);
        end
    endtask

    // Called at a negedge with the DUTs in IDLE; returns at the negedge of
    // the done cycle so a following call exercises start-during-done.
    task automatic run_drain(input logic [3:0][19:0] a,
                             input logic [3:0][15:0] e0, input logic [3:0] s0,
                             input logic [3:0][15:0] e1, input logic [3:0] s1,
                             input int rmode, input bit noise);
        int  k, cyc, stall;
        bit  first, r;
        for (int i = 0; i < 4; i++) acc[i] = a[i];
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 0; cyc = 0; stall = 0; first = 1'b1;
        while (k < 4 && cyc < 200) begin
            for (int d = 0; d < 2; d++) begin
                chk("beat_valid", d, 32'(vld[d]), 1);
                chk("beat_busy",  d, 32'(bsy[d]), 1);
                chk("beat_clear", d, 32'(clr[d]), 32'(first));
                chk("beat_done",  d, 32'(dn[d]),  0);
                chk("beat_index", d, 32'(idx[d]), 32'(k));
                chk("beat_last",  d, 32'(lst[d]), 32'(k == 3));
                chk("beat_data",  d, 32'(dat[d]), d == 0 ? 32'(e0[k]) : 32'(e1[k]));
                chk("beat_sat",   d, 32'(sat[d]), d == 0 ? 32'(s0[k]) : 32'(s1[k]));
            end
            // Accumulators move freely once the snapshot is taken.
            for (int i = 0; i < 4; i++) acc[i] = 20'($urandom);
            case (rmode)
                1:       r = 1'($urandom_range(0, 1));
                2:       r = !(k == 1 && stall < 3);
                default: r = 1'b1;
            endcase
            if (k == 1 && !r) stall++;
            out_ready = r;
            if (noise) start = (k == 3 && r) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clock);
            if (r) k++;
            @(negedge clock);
            first = 1'b0;
            cyc++;
        end
        if (k < 4) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: got %0d beats, expected 4", k);
        end
        for (int d = 0; d < 2; d++) begin
            chk("done_pulse", d, 32'(dn[d]),  1);
            chk("done_busy",  d, 32'(bsy[d]), 0);
            chk("done_valid", d, 32'(vld[d]), 0);
            chk("done_clear", d, 32'(clr[d]), 0);
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic run_random;
        logic [3:0][19:0] a;
        logic [3:0][15:0] e0, e1;
        logic [3:0]       s0, s1;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
                0:       a[i] = 20'($urandom_range(0, 65535));
                1:       a[i] = 20'($urandom);
                2:       a[i] = 20'hFFFFF;
                default: a[i] = 20'($urandom_range(65534, 65537));
            endcase
            ref_narrow(a[i], 0, e0[i], s0[i]);
            ref_narrow(a[i], 4, e1[i], s1[i]);
        end
        run_drain(a, e0, s0, e1, s1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        tbl[0] = '{a: {20'd400, 20'd300, 20'd200, 20'd100},
                   e0: {16'd400, 16'd300, 16'd200, 16'd100}, s0: 4'b0000,
                   e1: {16'd25, 16'd18, 16'd12, 16'd6},      s1: 4'b0000,
                   rmode: 0, noise: 1'b0};
        tbl[1] = '{a: {20'h0FFFF, 20'h0FFFF, 20'h0FFFF, 20'h12345},
                   e0: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, s0: 4'b0001,
                   e1: {16'h0FFF, 16'h0FFF, 16'h0FFF, 16'h1234}, s1: 4'b0000,
                   rmode: 0, noise: 1'b0};
        tbl[2] = '{a: {20'hFFFFF, 20'h0, 20'h0, 20'h12345},
                   e0: {16'hFFFF, 16'h0, 16'h0, 16'hFFFF}, s0: 4'b1001,
                   e1: {16'hFFFF, 16'h0, 16'h0, 16'h1234}, s1: 4'b0000,
                   rmode: 2, noise: 1'b1};
        tbl[3] = '{a: {20'h0, 20'h0FFFF, 20'h10000, 20'hFFFFF},
                   e0: {16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF}, s0: 4'b0011,
                   e1: {16'h0, 16'h0FFF, 16'h1000, 16'hFFFF}, s1: 4'b0000,
                   rmode: 1, noise: 1'b1};

        for (int i = 0; i < 4; i++) acc[i] = '0;
        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("reset_data",  d, 32'(dat[d]), 0);
            chk("reset_index", d, 32'(idx[d]), 0);
            chk("reset_last",  d, 32'(lst[d]), 0);
            chk("reset_sat",   d, 32'(sat[d]), 0);
        end
        check_idle("reset");
        reset = 1'b0;
        @(negedge clock);
        check_idle("post_reset");

        // Table vectors, first two chained through the done cycle.
        for (int t = 0; t < 4; t++) begin
            run_drain(tbl[t].a, tbl[t].e0, tbl[t].s0, tbl[t].e1, tbl[t].s1,
                      tbl[t].rmode, tbl[t].noise);
            if (t >= 1) begin
                @(negedge clock);
                check_idle("after_done");
            end
        end

        // Reset with two beats accepted and the third on the port.
        acc[0] = 20'd11; acc[1] = 20'd22; acc[2] = 20'd33; acc[3] = 20'd44;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) chk("pre_reset_index", d, 32'(idx[d]), 2);
        reset = 1'b1;
        #1;
        check_idle("mid_reset");
        for (int d = 0; d < 2; d++) chk("mid_reset_index", d, 32'(idx[d]), 0);
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        check_idle("after_mid_reset");
        run_drain({20'd4000, 20'd3000, 20'd2000, 20'd1000},
                  {16'd4000, 16'd3000, 16'd2000, 16'd1000}, 4'b0000,
                  {16'd250, 16'd187, 16'd125, 16'd62}, 4'b0000, 0, 1'b0);

        // Randomized drains, back to back.
        for (int n = 0; n < 12; n++) run_random();
        @(negedge clock);
        check_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
